// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit producing the HI/LO pair.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_hilo,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               neg;
  logic               is_div;

  assign is_div = op_q[1];
  assign is_sgn = ~op[0];
  assign mag_a  = (is_sgn && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign mag_b  = (is_sgn && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Multiply: acc = {partial, multiplier}; divide: acc = {rem, quotient}.
  assign add_sum = acc_q[0]
    ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q}
    : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
  assign shl  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff = shl - {1'b0, opnd_q};

  assign neg      = sign_a_q ^ sign_b_q;
  assign prod_fix = neg ? -acc_q : acc_q;
  assign quo_fix  = neg ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                             : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_CALC;
          op_d     = op;
          sign_a_d = is_sgn & operand_a[WIDTH-1];
          sign_b_d = is_sgn & operand_b[WIDTH-1];
          a_raw_d  = operand_a;
          cnt_d    = '0;
          opnd_d   = op[1] ? mag_b : mag_a;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, mag_a}
                           : {{WIDTH{1'b0}}, mag_b};
        end else if (!start) begin
          if (mt_hi) hi_d = mt_data;
          if (mt_lo) lo_d = mt_data;
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
          if (!is_div) begin
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (!is_div) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (opnd_q == '0) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy & (start | rd_hilo | mt_hi | mt_lo);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, stalls,
// abort, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] mt_data;
  logic        rd_hilo;
  logic        abort;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .rd_hilo(rd_hilo), .abort(abort), .busy(busy),
    .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait for done; lat = edges until done (-1 on timeout).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = busy ? 1 : 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo hi=%h lo=%h want 0/0", hi, lo);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b stall=%b want 000",
               busy, done, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat, bcnt;
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bcnt);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL multu_latency got=%0d want=33", lat);
    end
    checks++;
    if (bcnt !== 33) begin
      errors++;
      $display("FAIL multu_busy_cycles got=%0d want=33", bcnt);
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_result hi=%h lo=%h want fffffffe/00000001",
               hi, lo);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got=%b want=0", done);
    end
  endtask

  task automatic test_signed;
    int lat, bcnt;
    issue(MULT, 32'hFFFFFFF9, 32'h00000003);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_neg hi=%h lo=%h want ffffffff/ffffffeb", hi, lo);
    end
    issue(DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD || lat !== 33) begin
      errors++;
      $display("FAIL div_neg hi=%h lo=%h lat=%0d want ffffffff/fffffffd/33",
               hi, lo, lat);
    end
  endtask

  task automatic test_div_special;
    int lat, bcnt;
    issue(DIVU, 32'h00000064, 32'h00000000);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'h00000064 || lo !== 32'hFFFFFFFF || lat !== 33) begin
      errors++;
      $display("FAIL div_by_zero hi=%h lo=%h lat=%0d want 00000064/ffffffff/33",
               hi, lo, lat);
    end
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'h00000000 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow hi=%h lo=%h want 00000000/80000000",
               hi, lo);
    end
  endtask

  task automatic test_mt_stall;
    int lat, bcnt;
    @(negedge clk);
    mt_hi = 1'b1; mt_data = 32'h12345678;
    @(posedge clk);
    #1 mt_hi = 1'b0;
    checks++;
    if (hi !== 32'h12345678) begin
      errors++;
      $display("FAIL mthi_idle got=%h want=12345678", hi);
    end
    @(negedge clk);
    mt_lo = 1'b1; mt_data = 32'h0BADF00D;
    @(posedge clk);
    #1 mt_lo = 1'b0;
    checks++;
    if (lo !== 32'h0BADF00D || hi !== 32'h12345678) begin
      errors++;
      $display("FAIL mtlo_idle hi=%h lo=%h want 12345678/0badf00d", hi, lo);
    end
    issue(MULTU, 32'd2, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    mt_lo = 1'b1; rd_hilo = 1'b1; mt_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL busy_stall got=%b want=1", stall);
    end
    @(posedge clk);
    #1;
    mt_lo = 1'b0; rd_hilo = 1'b0;
    checks++;
    if (lo !== 32'h0BADF00D || hi !== 32'h12345678) begin
      errors++;
      $display("FAIL busy_mt_ignored hi=%h lo=%h want 12345678/0badf00d",
               hi, lo);
    end
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd6 || lat !== 23) begin
      errors++;
      $display("FAIL multu_2x3 hi=%h lo=%h lat=%0d want 0/6/23", hi, lo, lat);
    end
    @(negedge clk);
    rd_hilo = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_stall got=%b want=0", stall);
    end
    rd_hilo = 1'b0;
  endtask

  task automatic test_abort;
    int lat, bcnt;
    bit seen;
    issue(DIVU, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'd6) begin
      errors++;
      $display("FAIL abort_idle busy=%b hi=%h lo=%h want 0/0/6", busy, hi, lo);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got=%b want=0", seen);
    end
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = DIVU;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start busy=%b want=0", busy);
    end
    issue(DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'd2 || lo !== 32'd14 || lat !== 33) begin
      errors++;
      $display("FAIL divu_100_7 hi=%h lo=%h lat=%0d want 2/14/33",
               hi, lo, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt;
    issue(MULT, 32'd5, 32'd6);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h want 0/0/0/0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(MULTU, 32'd123, 32'd456);
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000DB18 || lat !== 33) begin
      errors++;
      $display("FAIL after_reset hi=%h lo=%h lat=%0d want 0/0000db18/33",
               hi, lo, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt;
    issue(MULTU, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = DIVU; operand_a = 32'd9; operand_b = 32'd3;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL start_busy_stall got=%b want=1", stall);
    end
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd12 || lat !== 28) begin
      errors++;
      $display("FAIL busy_start_ignored hi=%h lo=%h lat=%0d want 0/12/28",
               hi, lo, lat);
    end
    issue(MULT, 32'hFFFFFFF9, 32'h00000003);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b want=1", busy);
    end
    wait_done(lat, bcnt);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || lat !== 33) begin
      errors++;
      $display("FAIL b2b_result hi=%h lo=%h lat=%0d want ffffffff/ffffffeb/33",
               hi, lo, lat);
    end
  endtask

  initial begin
    start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    mt_hi = 1'b0; mt_lo = 1'b0; mt_data = '0;
    rd_hilo = 1'b0; abort = 1'b0;
    test_reset();
    test_multu();
    test_signed();
    test_div_special();
    test_mt_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
